// File: rtl/peak_tracker4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peak_tracker4_pkg
// Description : Shared constants for the peak_tracker4 frame statistics block:
//               sample width, FSM state encoding and rise saturation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package peak_tracker4_pkg;

    // Width of one sample and of every statistic derived from it
    localparam int c_data_w = 4;

    // FSM state encoding
    localparam int         c_state_w  = 2;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_track = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    // Rise counter ceiling (largest value a 4-bit count can hold)
    localparam logic [c_data_w-1:0] c_rise_max = 4'd15;

endpackage : peak_tracker4_pkg
`default_nettype wire

// File: rtl/peak_tracker4_if.sv
`default_nettype none
// ============================================================================
// Module      : peak_tracker4_if
// Description : Sample input stream and frame result stream of peak_tracker4.
//               master = producer/consumer side, slave = the tracker itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface peak_tracker4_if;
    import peak_tracker4_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [c_data_w-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [c_data_w-1:0] out_max;
    logic [c_data_w-1:0] out_min;
    logic [c_data_w-1:0] out_rise;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_max,
        input  out_min,
        input  out_rise
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_max,
        output out_min,
        output out_rise
    );

endinterface : peak_tracker4_if
`default_nettype wire

// File: rtl/peak_tracker4_mag_cmp4.sv
`default_nettype none
// ============================================================================
// Module      : mag_cmp4
// Description : 4-bit unsigned magnitude comparator (a vs b).
// Revision    : 1.0 - initial release
// ============================================================================
module mag_cmp4
    import peak_tracker4_pkg::*;
(
    input  wire logic [c_data_w-1:0] a,
    input  wire logic [c_data_w-1:0] b,
    output logic                     eq,
    output logic                     gt,
    output logic                     lt
);

    // Pure unsigned compares; exactly one flag is set for any input pair
    assign eq = (a == b);
    assign gt = (a >  b);
    assign lt = (a <  b);

endmodule : mag_cmp4
`default_nettype wire

// File: rtl/peak_tracker4.sv
`default_nettype none
// ============================================================================
// Module      : peak_tracker4
// Description : Collects FRAME_LEN samples, then presents max, min and the
//               number of rising steps of the frame until it is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module peak_tracker4
    import peak_tracker4_pkg::*;
#(
    parameter int FRAME_LEN = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    peak_tracker4_if.slave  bus
);

    localparam logic [c_data_w-1:0] c_frame_len = c_data_w'(FRAME_LEN);

    logic [c_state_w-1:0] r_state;
    logic [c_data_w-1:0]  r_max;
    logic [c_data_w-1:0]  r_min;
    logic [c_data_w-1:0]  r_prev;
    logic [c_data_w-1:0]  r_rise;
    logic [c_data_w-1:0]  r_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [c_data_w-1:0]  r_out_max;
    logic [c_data_w-1:0]  r_out_min;
    logic [c_data_w-1:0]  r_out_rise;

    logic w_eq_max,  w_gt_max,  w_lt_max;
    logic w_eq_min,  w_gt_min,  w_lt_min;
    logic w_eq_prev, w_gt_prev, w_lt_prev;

    logic [c_data_w-1:0] w_max_nxt;
    logic [c_data_w-1:0] w_min_nxt;
    logic [c_data_w-1:0] w_rise_nxt;
    logic [c_data_w-1:0] w_cnt_nxt;
    logic                w_accept;
    logic                w_unused;

    // New sample against the running maximum
    mag_cmp4 u_cmp_max (
        .a  (bus.in_data),
        .b  (r_max),
        .eq (w_eq_max),
        .gt (w_gt_max),
        .lt (w_lt_max)
    );

    // New sample against the running minimum
    mag_cmp4 u_cmp_min (
        .a  (bus.in_data),
        .b  (r_min),
        .eq (w_eq_min),
        .gt (w_gt_min),
        .lt (w_lt_min)
    );

    // New sample against its immediate predecessor
    mag_cmp4 u_cmp_prev (
        .a  (bus.in_data),
        .b  (r_prev),
        .eq (w_eq_prev),
        .gt (w_gt_prev),
        .lt (w_lt_prev)
    );

    // Only the strict flags drive updates; ties leave registers untouched
    assign w_unused = ^{w_eq_max, w_lt_max, w_eq_min, w_gt_min, w_eq_prev, w_lt_prev};

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_max_nxt  = w_gt_max ? bus.in_data : r_max;
    assign w_min_nxt  = w_lt_min ? bus.in_data : r_min;
    assign w_rise_nxt = (w_gt_prev && (r_rise != c_rise_max)) ? (r_rise + 4'd1) : r_rise;
    assign w_cnt_nxt  = r_cnt + 4'd1;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_max   = r_out_max;
    assign bus.out_min   = r_out_min;
    assign bus.out_rise  = r_out_rise;

    // Frame FSM with running statistics and registered result/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_max       <= '0;
            r_min       <= '0;
            r_prev      <= '0;
            r_rise      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_max   <= '0;
            r_out_min   <= '0;
            r_out_rise  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_max   <= bus.in_data;
                        r_min   <= bus.in_data;
                        r_prev  <= bus.in_data;
                        r_rise  <= '0;
                        r_cnt   <= 4'd1;
                        r_state <= c_st_track;
                    end
                end
                c_st_track: begin
                    if (w_accept) begin
                        r_max  <= w_max_nxt;
                        r_min  <= w_min_nxt;
                        r_prev <= bus.in_data;
                        r_rise <= w_rise_nxt;
                        r_cnt  <= w_cnt_nxt;
                        // Last sample of the frame: publish the final statistics
                        if (w_cnt_nxt == c_frame_len) begin
                            r_state     <= c_st_hold;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_max   <= w_max_nxt;
                            r_out_min   <= w_min_nxt;
                            r_out_rise  <= w_rise_nxt;
                        end
                    end
                end
                c_st_hold: begin
                    // Inputs are ignored until the consumer takes the result
                    if (bus.out_ready) begin
                        r_state     <= c_st_idle;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : peak_tracker4
`default_nettype wire
